// File: rtl/dead_time_gen_if.sv
// Leg interface: enable/PWM/fault controls toward dead_time_gen; gate commands and status back.
// Combinational bundle only; clock and reset stay plain ports on the block.
interface dead_time_gen_if;
    logic enable;
    logic pwm_in;
    logic fault_in;
    logic fault_clr;
    logic gate_hi;
    logic gate_lo;
    logic in_dead_time;
    logic fault_latched;

    modport master (
        output enable, pwm_in, fault_in, fault_clr,
        input  gate_hi, gate_lo, in_dead_time, fault_latched
    );

    modport slave (
        input  enable, pwm_in, fault_in, fault_clr,
        output gate_hi, gate_lo, in_dead_time, fault_latched
    );
endinterface

// File: rtl/dead_time_gen.sv
// Dead-time generator for one inverter leg: complementary registered gates, shoot-through lockout, sticky fault.
// Gate falls 2 edges after pwm_in changes, incoming gate DEAD_CYCLES later; DTG_MIN_PULSE_EN adds a MIN_PULSE glitch filter.
module dead_time_gen #(
    parameter int DEAD_CYCLES = 50,
    parameter int MIN_PULSE   = 10
) (
    input  logic           clk_50,
    input  logic           rst,
    dead_time_gen_if.slave dif
);
    localparam int            CW     = $clog2(DEAD_CYCLES + 1);
    localparam logic [CW-1:0] RELOAD = CW'(DEAD_CYCLES - 1);

    if (DEAD_CYCLES < 1 || DEAD_CYCLES > 1023) begin : g_bad_dead_cycles
        $error("dead_time_gen: DEAD_CYCLES must be within 1..1023");
    end
    if (MIN_PULSE < 1) begin : g_bad_min_pulse
        $error("dead_time_gen: MIN_PULSE must be at least 1");
    end

    logic pwm_q;

`ifdef DTG_MIN_PULSE_EN
    localparam int FW = $clog2(MIN_PULSE + 1);

    logic [FW-1:0] flt_cnt_q, flt_cnt_d;
    logic          pwm_d;

    // A new level is accepted on its MIN_PULSE-th consecutive sample; any bounce restarts the count.
    always_comb begin
        flt_cnt_d = '0;
        pwm_d     = pwm_q;
        if (dif.pwm_in != pwm_q) begin
            if (flt_cnt_q == FW'(MIN_PULSE - 1)) begin
                pwm_d = dif.pwm_in;
            end else begin
                flt_cnt_d = flt_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_50 or negedge rst) begin
        if (!rst) begin
            flt_cnt_q <= '0;
            pwm_q     <= 1'b0;
        end else begin
            flt_cnt_q <= flt_cnt_d;
            pwm_q     <= pwm_d;
        end
    end
`else
    always_ff @(posedge clk_50 or negedge rst) begin
        if (!rst) begin
            pwm_q <= 1'b0;
        end else begin
            pwm_q <= dif.pwm_in;
        end
    end
`endif

    typedef enum logic [2:0] {IDLE, DT, HI_ON, LO_ON, FAULT} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          tgt_q;
    logic          gate_hi_q;
    logic          gate_lo_q;
    logic          dt_q;
    logic          fault_q;

    // Branch order encodes priority: fault, then disable, then PWM change, then counter expiry.
    always_ff @(posedge clk_50 or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            tgt_q     <= 1'b0;
            gate_hi_q <= 1'b0;
            gate_lo_q <= 1'b0;
            dt_q      <= 1'b0;
            fault_q   <= 1'b0;
        end else if (dif.fault_in) begin
            state_q   <= FAULT;
            cnt_q     <= '0;
            gate_hi_q <= 1'b0;
            gate_lo_q <= 1'b0;
            dt_q      <= 1'b0;
            fault_q   <= 1'b1;
        end else if (state_q == FAULT) begin
            if (dif.fault_clr) begin
                state_q <= IDLE;
                fault_q <= 1'b0;
            end
        end else if (!dif.enable) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            gate_hi_q <= 1'b0;
            gate_lo_q <= 1'b0;
            dt_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= DT;
                    cnt_q   <= RELOAD;
                    tgt_q   <= pwm_q;
                    dt_q    <= 1'b1;
                end
                DT: begin
                    if (pwm_q != tgt_q) begin
                        cnt_q <= RELOAD;
                        tgt_q <= pwm_q;
                    end else if (cnt_q == '0) begin
                        state_q   <= tgt_q ? HI_ON : LO_ON;
                        gate_hi_q <= tgt_q;
                        gate_lo_q <= !tgt_q;
                        dt_q      <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                HI_ON, LO_ON: begin
                    if (pwm_q != tgt_q) begin
                        state_q   <= DT;
                        cnt_q     <= RELOAD;
                        tgt_q     <= pwm_q;
                        gate_hi_q <= 1'b0;
                        gate_lo_q <= 1'b0;
                        dt_q      <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dif.gate_hi       = gate_hi_q;
    assign dif.gate_lo       = gate_lo_q;
    assign dif.in_dead_time  = dt_q;
    assign dif.fault_latched = fault_q;
endmodule
